pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
Parameterised pipeline stage register for the CPU datapath. It is the successor to the plain load/hold/clear stage register. It replaces the 2-bit choice control with a valid/ready handshake on both sides, plus a synchronous flush. An optional skid entry gives full throughput with a registered in_ready, so stall signals do not ripple combinationally through the pipe.

Parameters:
WIDTH, 32, payload width in bits (>=1).
RESET_VALUE, 0 (WIDTH bits), value loaded into data registers on reset and flush.
SKID, 1, 1 = two-entry skid stage with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
flush  in  1  synchronous kill of all held entries (branch/exception squash).
in_valid  in  1  upstream has data.
in_ready  out  1  stage accepts data this cycle.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts.
out_data  out  WIDTH  payload of the head entry.
occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0).

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data is never duplicated or lost except by flush.
- Reset (async, any time, including mid-transfer): main and skid valid = 0; main and skid data = RESET_VALUE; out_valid=0; out_data=RESET_VALUE; occupancy=0. in_ready=1 for both SKID settings.
- Flush (sync, highest priority over all transfers): next cycle both entries are invalid and both data registers = RESET_VALUE.
  - An in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle counts as delivered to downstream.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N. Sustained throughput is 1 word/cycle with out_ready held high.
- Ordering: strict FIFO.
- SKID=1 states, keyed by (main_v, skid_v):
  - EMPTY (0,0): in_ready=1. in_fire -> ONE, main=in_data.
  - ONE (1,0): in_ready=1.
    - in_fire & out_fire -> ONE, main=in_data.
    - in_fire only -> FULL, skid=in_data.
    - out_fire only -> EMPTY.
    - neither -> hold.
  - FULL (1,1): in_ready=0. out_fire -> ONE, main=skid. No out_fire -> hold.
  - in_ready is registered: in_ready = !skid_v.
- SKID=0 behaviour:
  - in_ready = !main_v | out_ready (combinational path from out_ready).
  - in_fire loads main; out_fire without in_fire clears main_v.
- Data hold: when an entry empties without refill, its data register keeps its last value (no clear). Benches check out_data only while out_valid=1, except after reset/flush, when it must equal RESET_VALUE.
- occupancy = main_v + skid_v, registered.
- Illegal state (skid_v=1, main_v=0) is unreachable; an assertion flags it.
- in_data is sampled only on in_fire. in_valid may drop without in_fire (no stickiness required upstream).

Decomposition:
- Shared pipeline package holds:
  - occupancy width constant (2);
  - state encoding constants EMPTY/ONE/FULL, used by the bench for coverage;
  - default RESET_VALUE constant for the datapath.
- One natural sub-module: pipe_entry_reg, a WIDTH-bit register with async reset to RESET_VALUE and inputs load/clear. It is instantiated for main and skid; the SKID=0 build omits the skid entry via generate.
- Handshake/state logic stays in the top module.

Test Plan:
- Reset mid-stream: fill FULL with 0xA1, 0xA2, then assert reset -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE immediately (async).
- Streaming, SKID=1, out_ready=1: push 0x10..0x17 back-to-back -> outputs 0x10..0x17, each one cycle after accept, in_ready stays 1.
- Backpressure: out_ready=0, push 0x55 then 0x66.
  - Required: occupancy 1 then 2, in_ready=0 on the third cycle.
  - Then out_ready=1: 0x55 then 0x66 delivered, in_ready=1 one cycle after the first pop.
- Simultaneous flush and in_fire in state ONE (main=0x33, in_data=0x44) -> next cycle out_valid=0, occupancy=0, out_data=RESET_VALUE, 0x44 never appears.
- SKID=0: out_ready=0 with main holding 0x77 -> in_ready=0. Raise out_ready while in_valid=1 with 0x88 -> same-cycle in_ready=1, next cycle out_data=0x88.
- Random valid/ready, 1000 cycles, flush 2% of cycles -> scoreboard: output sequence equals accepted inputs minus flushed entries, in order; occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// rtl/pipe_skid_stage_pkg.sv - shared constants and types for the skid pipeline stage
//
// Contents:
//   OCC_W               width of the occupancy count (0..2)
//   DEFAULT_RESET_VALUE datapath reset/flush value used when none is given
//   pipe_state_e        stage state, encoded as {main_v, skid_v}
package pipe_skid_stage_pkg;

   localparam int OCC_W = 2;

   localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h0000_0000;

   // Bit 1 is the main entry valid flag, bit 0 the skid entry valid flag.
   // 2'b01 (skid without main) is deliberately not a member.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } pipe_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload register with load and synchronous clear
//
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset, q <= RESET_VALUE
//   load   capture d on the next edge
//   clear  load RESET_VALUE on the next edge (wins over load)
//   d      payload input
//   q      registered payload
module pipe_entry_reg
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else if (clear) begin
         q <= RESET_VALUE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with optional skid entry
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream has data
//   in_ready   stage accepts data this cycle
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts
//   out_data   payload of the head entry
//   occupancy  number of valid entries
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE),
   parameter int               SKID        = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic             main_v;
   logic             skid_v;
   logic             in_fire;
   logic             out_fire;
   logic             main_load;
   logic             main_from_skid;
   logic             skid_load;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   assign main_v = state_q[1];
   assign skid_v = state_q[0];

   // With the skid entry, in_ready depends only on a flop, so a stall
   // never propagates combinationally upstream. Without it, a full main
   // entry can still accept when it is being drained in the same cycle.
   generate
      if (SKID != 0) begin : g_ready_reg
         assign in_ready = ~skid_v;
      end else begin : g_ready_comb
         assign in_ready = ~main_v | out_ready;
      end
   endgenerate

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;
   assign out_valid = main_v;
   assign out_data  = main_q;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  // Only reachable with the skid entry present; the
                  // single-entry build accepts here only while draining.
                  if (SKID != 0) begin
                     state_d   = ST_FULL;
                     skid_load = 1'b1;
                  end else begin
                     main_load = 1'b1;
                  end
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d        = ST_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   pipe_entry_reg #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clear (flush),
      .d     (main_d),
      .q     (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry_reg #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .clear (flush),
            .d     (in_data),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = RESET_VALUE;
      end
   endgenerate

   // A skid word without a main word would break FIFO order.
   a_no_orphan_skid : assert property (@(posedge clk) disable iff (reset) !(skid_v && !main_v));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage (SKID=1 and SKID=0)
module tb_pipe_skid_stage;
   import pipe_skid_stage_pkg::*;

   localparam int          W  = 8;
   localparam logic [W-1:0] RV = 8'hE5;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         flush     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data   = '0;

   logic         in_ready1, out_valid1;
   logic [W-1:0] out_data1;
   logic [1:0]   occ1;
   logic         in_ready0, out_valid0;
   logic [W-1:0] out_data0;
   logic [1:0]   occ0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_data   (in_data),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_data  (out_data1),
      .occupancy (occ1)
   );

   pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV), .SKID(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_data   (in_data),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_data  (out_data0),
      .occupancy (occ0)
   );

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid1: got %b want 0", out_valid1); end
      n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready1: got %b want 1", in_ready1); end
      n_cmp++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL reset_occ1: got %0d want 0", occ1); end
      n_cmp++; if (out_data1 !== RV) begin n_err++; $display("FAIL reset_out_data1: got %h want %h", out_data1, RV); end
      n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid0: got %b want 0", out_valid0); end
      n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready0: got %b want 1", in_ready0); end
      n_cmp++; if (out_data0 !== RV) begin n_err++; $display("FAIL reset_out_data0: got %h want %h", out_data0, RV); end
      reset = 1'b0;
   endtask

   task automatic test_reset_midstream();
      do_flush();
      @(negedge clk); in_valid = 1'b1; in_data = 8'hA1;
      @(negedge clk); in_data = 8'hA2;
      @(negedge clk); in_valid = 1'b0;
      #1;
      n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL midrst_full_occ: got %0d want 2", occ1); end
      reset = 1'b1;
      #1;
      n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid1); end
      n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready1); end
      n_cmp++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL midrst_occ: got %0d want 0", occ1); end
      n_cmp++; if (out_data1 !== RV) begin n_err++; $display("FAIL midrst_out_data: got %h want %h", out_data1, RV); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_streaming();
      logic [W-1:0] exp;
      do_flush();
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i < 8) begin in_valid = 1'b1; in_data = 8'h10 + W'(i); end
         else in_valid = 1'b0;
         #1;
         if (i < 8) begin
            n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready1); end
         end
         if (i > 0) begin
            exp = 8'h10 + W'(i - 1);
            n_cmp++;
            if (out_valid1 !== 1'b1 || out_data1 !== exp) begin
               n_err++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid1, out_data1, exp);
            end
         end
      end
      @(negedge clk); #1;
      n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b want 0", out_valid1); end
   endtask

   task automatic test_backpressure();
      do_flush();
      @(negedge clk); in_valid = 1'b1; in_data = 8'h55; #1;
      n_cmp++; if (in_ready1 !== 1'b1 || occ1 !== 2'd0) begin n_err++; $display("FAIL bp_c1: got rdy=%b occ=%0d want rdy=1 occ=0", in_ready1, occ1); end
      @(negedge clk); in_data = 8'h66; #1;
      n_cmp++; if (occ1 !== 2'd1 || in_ready1 !== 1'b1 || out_data1 !== 8'h55) begin n_err++; $display("FAIL bp_c2: got occ=%0d rdy=%b d=%h want occ=1 rdy=1 d=55", occ1, in_ready1, out_data1); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_cmp++; if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin n_err++; $display("FAIL bp_c3: got occ=%0d rdy=%b want occ=2 rdy=0", occ1, in_ready1); end
      out_ready = 1'b1; #1;
      n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h55) begin n_err++; $display("FAIL bp_pop1: got v=%b d=%h want v=1 d=55", out_valid1, out_data1); end
      @(negedge clk); #1;
      n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h66 || in_ready1 !== 1'b1 || occ1 !== 2'd1) begin
         n_err++; $display("FAIL bp_pop2: got v=%b d=%h rdy=%b occ=%0d want v=1 d=66 rdy=1 occ=1", out_valid1, out_data1, in_ready1, occ1);
      end
      @(negedge clk); #1;
      n_cmp++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin n_err++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid1, occ1); end
   endtask

   task automatic test_flush_in_one();
      do_flush();
      @(negedge clk); in_valid = 1'b1; in_data = 8'h33;
      @(negedge clk); flush = 1'b1; in_data = 8'h44; #1;
      n_cmp++; if (occ1 !== 2'd1 || out_data1 !== 8'h33 || in_ready1 !== 1'b1) begin
         n_err++; $display("FAIL flush_pre: got occ=%0d d=%h rdy=%b want occ=1 d=33 rdy=1", occ1, out_data1, in_ready1);
      end
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
      n_cmp++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_data1 !== RV) begin
         n_err++; $display("FAIL flush_post: got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", out_valid1, occ1, out_data1, RV);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL flush_dropped[%0d]: got v=%b d=%h want v=0", i, out_valid1, out_data1); end
      end
   endtask

   task automatic test_skid0();
      do_flush();
      @(negedge clk); in_valid = 1'b1; in_data = 8'h77; #1;
      n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL s0_empty_ready: got %b want 1", in_ready0); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h77 || in_ready0 !== 1'b0) begin
         n_err++; $display("FAIL s0_hold: got v=%b d=%h rdy=%b want v=1 d=77 rdy=0", out_valid0, out_data0, in_ready0);
      end
      @(negedge clk); in_valid = 1'b1; in_data = 8'h88; #1;
      n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL s0_stalled: got %b want 0", in_ready0); end
      out_ready = 1'b1; #1;
      n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL s0_comb_ready: got %b want 1", in_ready0); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h88 || occ0 !== 2'd1) begin
         n_err++; $display("FAIL s0_refill: got v=%b d=%h occ=%0d want v=1 d=88 occ=1", out_valid0, out_data0, occ0);
      end
      @(negedge clk); #1;
      n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL s0_drain: got %b want 0", out_valid0); end
   endtask

   // Reference: a FIFO of capacity 2 (skid) or 1 (no skid); flush empties it.
   task automatic test_random(input bit skid, input int cycles);
      logic [W-1:0] q[$];
      bit           fresh = 1'b1;
      bit           exp_rdy, inf, outf;
      logic         o_rdy, o_v;
      logic [W-1:0] o_d;
      logic [1:0]   o_occ;
      int           seen[3] = '{0, 0, 0};
      do_flush();
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 50) == 0;
         in_data   = W'($urandom);
         #1;
         o_rdy = skid ? in_ready1  : in_ready0;
         o_v   = skid ? out_valid1 : out_valid0;
         o_d   = skid ? out_data1  : out_data0;
         o_occ = skid ? occ1       : occ0;
         exp_rdy = skid ? (q.size() < 2) : (q.size() == 0 || out_ready);
         n_cmp++; if (o_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd%0d_in_ready c=%0d: got %b want %b", skid, c, o_rdy, exp_rdy); end
         n_cmp++; if (o_v !== (q.size() > 0)) begin n_err++; $display("FAIL rnd%0d_out_valid c=%0d: got %b want %b", skid, c, o_v, q.size() > 0); end
         n_cmp++; if (int'(o_occ) != q.size() || int'(o_occ) > (skid ? 2 : 1)) begin
            n_err++; $display("FAIL rnd%0d_occupancy c=%0d: got %0d want %0d", skid, c, o_occ, q.size());
         end
         if (q.size() > 0) begin
            n_cmp++; if (o_d !== q[0]) begin n_err++; $display("FAIL rnd%0d_out_data c=%0d: got %h want %h", skid, c, o_d, q[0]); end
         end else if (fresh) begin
            n_cmp++; if (o_d !== RV) begin n_err++; $display("FAIL rnd%0d_rv_data c=%0d: got %h want %h", skid, c, o_d, RV); end
         end
         if (o_occ < 2'd3) seen[o_occ]++;
         inf  = in_valid && exp_rdy;
         outf = (q.size() > 0) && out_ready;
         if (flush) begin
            q.delete();
            fresh = 1'b1;
         end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin q.push_back(in_data); fresh = 1'b0; end
         end
      end
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++; if (seen[ST_EMPTY == ST_EMPTY ? 0 : 0] == 0 || seen[1] == 0) begin
         n_err++; $display("FAIL rnd%0d_cover: got empty=%0d one=%0d want both >0", skid, seen[0], seen[1]);
      end
      if (skid) begin
         n_cmp++; if (seen[2] == 0) begin n_err++; $display("FAIL rnd1_cover_full: got %0d want >0", seen[2]); end
      end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_streaming();
      test_backpressure();
      test_flush_in_one();
      test_skid0();
      test_random(1'b1, 1000);
      test_random(1'b0, 400);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
